// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
//   Shared constants for the 3-stage core's register-file write side.
//   XLEN   : data width of the integer datapath
//   REG_AW : register address width
//   NREG   : number of architectural registers
//   REG_X0 : index of the hard-wired zero register
//   wb_sel_e : which source owns the register-file write port this cycle
// ----------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 1 << REG_AW;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_SKID = 2'd2,
        SEL_EX   = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/wb_tag_fifo.sv
// ----------------------------------------------------------------------------
// wb_tag_fifo
//   Holds the destination register of every outstanding load, in issue order.
//   The head is the destination of the next load response to arrive.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     push, push_data   enqueue a destination (ignored when full)
//     pop               dequeue the head (ignored when empty)
//     full, empty       occupancy flags
//     head              destination at the front of the queue
// ----------------------------------------------------------------------------
module wb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign head    = mem[rd_ptr[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rf_writeback.sv
// ----------------------------------------------------------------------------
// rf_writeback
//   Sole driver of the register-file write port. Merges single-cycle ALU
//   results with in-order load responses, tracks outstanding load
//   destinations and exports a pending mask for hazard stalls.
//   Ports:
//     clk, rst_n                    clock, asynchronous active-low reset
//     ex_valid/ex_ready/ex_rd/ex_data          ALU result handshake
//     ld_req_valid/ld_req_ready/ld_req_rd      load issue handshake
//     ld_rsp_valid/ld_rsp_data                 load data (no back-pressure)
//     rf_wen/rf_addr/rf_data        registered register-file write
//     pending                       per-register outstanding-write mask
//     rsp_err                       sticky: response arrived with no load
// ----------------------------------------------------------------------------
module rf_writeback
    import rv32_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [REG_AW-1:0] ld_req_rd,
    input  logic              ld_rsp_valid,
    input  logic [XLEN-1:0]   ld_rsp_data,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_addr,
    output logic [XLEN-1:0]   rf_data,
    output logic [NREG-1:0]   pending,
    output logic              rsp_err
);

    logic              fifo_full;
    logic              fifo_empty;
    logic [REG_AW-1:0] fifo_head;

    logic              skid_valid;
    logic [REG_AW-1:0] skid_rd;
    logic [XLEN-1:0]   skid_data;

    logic              ex_fire;
    logic              ld_req_fire;
    logic              ld_pop;
    logic              ex_to_skid;

    wb_sel_e           sel;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [NREG-1:0]   pending_nxt;

    // Readiness is computed from registered state only, so a response popping
    // a full FIFO never lets a new load slip in during the same cycle.
    assign ex_ready     = !skid_valid && !((ex_rd != REG_X0) && pending[ex_rd]);
    assign ld_req_ready = !fifo_full && !((ld_req_rd != REG_X0) && pending[ld_req_rd]);

    assign ex_fire     = ex_valid && ex_ready;
    assign ld_req_fire = ld_req_valid && ld_req_ready;
    assign ld_pop      = ld_rsp_valid && !fifo_empty;
    // A response owns the port even when it targets x0 or is spurious, so an
    // ALU result arriving alongside it always waits in the skid.
    assign ex_to_skid  = ex_fire && ld_rsp_valid;

    wb_tag_fifo #(
        .DEPTH (LD_DEPTH),
        .W     (REG_AW)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ld_req_fire),
        .push_data (ld_req_rd),
        .pop       (ld_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Write-source priority: load response, then skid, then direct ALU result.
    always_comb begin
        sel      = SEL_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (ld_rsp_valid) begin
            if (!fifo_empty) begin
                sel      = SEL_LOAD;
                sel_rd   = fifo_head;
                sel_data = ld_rsp_data;
            end
        end else if (skid_valid) begin
            sel      = SEL_SKID;
            sel_rd   = skid_rd;
            sel_data = skid_data;
        end else if (ex_fire) begin
            sel      = SEL_EX;
            sel_rd   = ex_rd;
            sel_data = ex_data;
        end
    end

    // Clears and sets never hit the same bit: sets are gated by ready, which
    // already requires the bit to be clear.
    always_comb begin
        pending_nxt = pending;
        if (ld_pop)          pending_nxt[fifo_head] = 1'b0;
        if (sel == SEL_SKID) pending_nxt[skid_rd]   = 1'b0;
        if (ld_req_fire)     pending_nxt[ld_req_rd] = 1'b1;
        if (ex_to_skid)      pending_nxt[ex_rd]     = 1'b1;
        pending_nxt[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_rd    <= '0;
            skid_data  <= '0;
        end else if (ex_to_skid) begin
            skid_valid <= 1'b1;
            skid_rd    <= ex_rd;
            skid_data  <= ex_data;
        end else if (sel == SEL_SKID) begin
            skid_valid <= 1'b0;
        end
    end

    // x0 writes still consume the slot but never raise the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen  <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_wen  <= (sel != SEL_NONE) && (sel_rd != REG_X0);
            rf_addr <= sel_rd;
            rf_data <= sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (ld_rsp_valid && fifo_empty) begin
            rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// ----------------------------------------------------------------------------
// tb_rf_writeback
//   Directed bench for rf_writeback: ALU write, in-order loads, load/ALU
//   collision through the skid, full tag FIFO, WAW stalls, x0 handling,
//   spurious responses and asynchronous reset in the middle of traffic.
// ----------------------------------------------------------------------------
module tb_rf_writeback;

    import rv32_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic              ex_ready;
    logic [REG_AW-1:0] ex_rd;
    logic [XLEN-1:0]   ex_data;
    logic              ld_req_valid;
    logic              ld_req_ready;
    logic [REG_AW-1:0] ld_req_rd;
    logic              ld_rsp_valid;
    logic [XLEN-1:0]   ld_rsp_data;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_addr;
    logic [XLEN-1:0]   rf_data;
    logic [NREG-1:0]   pending;
    logic              rsp_err;

    int checks   = 0;
    int failures = 0;

    rf_writeback #(.LD_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_rd        (ex_rd),
        .ex_data      (ex_data),
        .ld_req_valid (ld_req_valid),
        .ld_req_ready (ld_req_ready),
        .ld_req_rd    (ld_req_rd),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_data  (ld_rsp_data),
        .rf_wen       (rf_wen),
        .rf_addr      (rf_addr),
        .rf_data      (rf_data),
        .pending      (pending),
        .rsp_err      (rsp_err)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on a miss counts and reports it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's worth of inputs and lets combinational paths settle.
    task automatic applyStimulus(input logic exv, input logic [REG_AW-1:0] exr,
                                 input logic [XLEN-1:0] exd, input logic lqv,
                                 input logic [REG_AW-1:0] lqr, input logic rsv,
                                 input logic [XLEN-1:0] rsd);
        ex_valid     = exv;
        ex_rd        = exr;
        ex_data      = exd;
        ld_req_valid = lqv;
        ld_req_rd    = lqr;
        ld_rsp_valid = rsv;
        ld_rsp_data  = rsd;
        #1;
    endtask

    // Clocks the applied inputs in, then idles all valids just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ex_valid     = 1'b0;
        ld_req_valid = 1'b0;
        ld_rsp_valid = 1'b0;
        #1;
    endtask

    // Directed sequence; each step's expected values are worked out by hand.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
        #12;
        checkOutput("reset_rf_wen",  64'(rf_wen),  64'h0);
        checkOutput("reset_pending", 64'(pending), 64'h0);
        checkOutput("reset_rsp_err", 64'(rsp_err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_ld_req_ready", 64'(ld_req_ready), 64'h1);
        checkOutput("post_reset_ex_ready",     64'(ex_ready),     64'h1);

        // Direct ALU write lands one cycle later, for exactly one cycle.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        checkOutput("ex_wen",  64'(rf_wen),  64'h1);
        checkOutput("ex_addr", 64'(rf_addr), 64'd5);
        checkOutput("ex_data", 64'(rf_data), 64'hDEADBEEF);
        tick();
        checkOutput("ex_wen_drop", 64'(rf_wen), 64'h0);

        // Two loads, responses return in issue order.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0);
        tick();
        checkOutput("ld3_pending", 64'(pending), 64'h8);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 32'h0);
        tick();
        checkOutput("ld37_pending", 64'(pending), 64'h88);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h11);
        tick();
        checkOutput("rsp3_wen",     64'(rf_wen),  64'h1);
        checkOutput("rsp3_addr",    64'(rf_addr), 64'd3);
        checkOutput("rsp3_data",    64'(rf_data), 64'h11);
        checkOutput("rsp3_pending", 64'(pending), 64'h80);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'h22);
        tick();
        checkOutput("rsp7_addr",    64'(rf_addr), 64'd7);
        checkOutput("rsp7_data",    64'(rf_data), 64'h22);
        checkOutput("rsp7_pending", 64'(pending), 64'h0);

        // Load response and ALU result collide: ALU result parks in the skid.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b1, 32'h33);
        checkOutput("collide_ex_ready", 64'(ex_ready), 64'h1);
        tick();
        checkOutput("collide_ld_addr",  64'(rf_addr), 64'd4);
        checkOutput("collide_ld_data",  64'(rf_data), 64'h33);
        checkOutput("skid_ex_ready",    64'(ex_ready), 64'h0);
        checkOutput("skid_pending",     64'(pending),  64'h200);
        tick();
        checkOutput("skid_wen",         64'(rf_wen),   64'h1);
        checkOutput("skid_addr",        64'(rf_addr),  64'd9);
        checkOutput("skid_data",        64'(rf_data),  64'h55);
        checkOutput("skid_pending_clr", 64'(pending),  64'h0);
        checkOutput("skid_ex_ready_up", 64'(ex_ready), 64'h1);

        // Fill the tag FIFO with four loads.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 32'h0);
        tick();
        checkOutput("full_pending", 64'(pending), 64'h4E);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 1'b0, 32'h0);
        checkOutput("full_ld_req_ready", 64'(ld_req_ready), 64'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hA1);
        tick();
        checkOutput("rsp1_addr",    64'(rf_addr), 64'd1);
        checkOutput("rsp1_pending", 64'(pending), 64'h4C);

        // Stalls against outstanding loads; x0 ALU write is silent.
        applyStimulus(1'b0, 5'd2, 32'h0, 1'b0, 5'd3, 1'b0, 32'h0);
        checkOutput("waw_ld_req_ready", 64'(ld_req_ready), 64'h0);
        checkOutput("waw_ex_ready",     64'(ex_ready),     64'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd10, 1'b0, 32'h0);
        checkOutput("free_ld_req_ready", 64'(ld_req_ready), 64'h1);
        applyStimulus(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 1'b0, 32'h0);
        checkOutput("x0_ex_ready", 64'(ex_ready), 64'h1);
        tick();
        checkOutput("x0_ex_wen", 64'(rf_wen), 64'h0);

        // Drain the rest in order.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hA2);
        tick();
        checkOutput("rsp2_addr", 64'(rf_addr), 64'd2);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hA3);
        tick();
        checkOutput("rsp3b_addr", 64'(rf_addr), 64'd3);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hA6);
        tick();
        checkOutput("rsp6_addr",    64'(rf_addr), 64'd6);
        checkOutput("rsp6_data",    64'(rf_data), 64'hA6);
        checkOutput("drain_pending", 64'(pending), 64'h0);

        // x0 load occupies and pops a tag but writes nothing.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 32'h0);
        tick();
        checkOutput("x0_ld_pending", 64'(pending), 64'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hBB);
        tick();
        checkOutput("x0_rsp_wen",     64'(rf_wen),  64'h0);
        checkOutput("x0_rsp_rsp_err", 64'(rsp_err), 64'h0);

        // Spurious response: sticky error, no write.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 32'hCC);
        tick();
        checkOutput("spurious_rsp_err", 64'(rsp_err), 64'h1);
        checkOutput("spurious_wen",     64'(rf_wen),  64'h0);
        tick();
        checkOutput("sticky_rsp_err",   64'(rsp_err), 64'h1);

        // Reset in the middle of traffic clears everything immediately.
        applyStimulus(1'b1, 5'd12, 32'h00C0FFEE, 1'b1, 5'd8, 1'b0, 32'h0);
        tick();
        checkOutput("pre_reset_wen",     64'(rf_wen),  64'h1);
        checkOutput("pre_reset_pending", 64'(pending), 64'h100);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_wen",     64'(rf_wen),  64'h0);
        checkOutput("async_reset_addr",    64'(rf_addr), 64'h0);
        checkOutput("async_reset_data",    64'(rf_data), 64'h0);
        checkOutput("async_reset_pending", 64'(pending), 64'h0);
        checkOutput("async_reset_rsp_err", 64'(rsp_err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 1'b0, 32'h0);
        checkOutput("after_reset_ld_req_ready", 64'(ld_req_ready), 64'h1);
        checkOutput("after_reset_pending",      64'(pending),      64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
